// File: rtl/alu_ctrl_pkg.sv
// Shared ALU Operation codes and ALUOp classes for the decoder and the ALU.
package alu_ctrl_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0101;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0111;
  localparam logic [OP_W-1:0] OP_EQ  = 4'b1000;
  localparam logic [OP_W-1:0] OP_NE  = 4'b1001;
  localparam logic [OP_W-1:0] OP_SLT = 4'b1100;
  localparam logic [OP_W-1:0] OP_SRA = 4'b1110;
  localparam logic [OP_W-1:0] OP_SRL = 4'b1111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational map from (ALUOp, Funct3, Funct7) to the ALU Operation code.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      Funct3,
  input  logic [6:0]      Funct7,
  output logic [OP_W-1:0] op,
  output logic            illegal
);

  // Illegal encodings fall through to ADD with the illegal flag raised.
  always_comb begin
    op      = OP_ADD;
    illegal = 1'b0;
    unique case (alu_op_e'(ALUOp))
      ALUOP_MEM: op = OP_ADD;
      ALUOP_BR: begin
        case (Funct3)
          3'b000:  op = OP_EQ;
          3'b001:  op = OP_NE;
          3'b100:  op = OP_SLT;
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_R, ALUOP_I: begin
        case (Funct3)
          3'b000: begin
            if (alu_op_e'(ALUOp) == ALUOP_I || Funct7 == F7_ZERO) op = OP_ADD;
            else if (Funct7 == F7_ALT)                            op = OP_SUB;
            else                                                  illegal = 1'b1;
          end
          3'b001: begin
            if (Funct7 == F7_ZERO) op = OP_SLL;
            else                   illegal = 1'b1;
          end
          3'b010: op = OP_SLT;
          3'b100: op = OP_XOR;
          3'b101: begin
            if (Funct7 == F7_ZERO)     op = OP_SRL;
            else if (Funct7 == F7_ALT) op = OP_SRA;
            else                       illegal = 1'b1;
          end
          3'b110: op = OP_OR;
          3'b111: op = OP_AND;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_stage.sv
// ID/EX ALU control stage: decode, main+skid output registers with valid/ready,
// and a saturating count of accepted illegal ops.
module alu_control_stage
  import alu_ctrl_pkg::*;
#(
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_illegal,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic [CNT_WIDTH-1:0]     illegal_count
);

  logic [OP_W-1:0]          dec_op;
  logic                     dec_illegal;
  logic                     skid_valid;
  logic [OPCODE_LENGTH-1:0] skid_op;
  logic                     skid_illegal;
  logic [TAG_WIDTH-1:0]     skid_tag;
  logic                     accept;
  logic                     main_free;

  alu_op_decode u_decode (
    .ALUOp   (ALUOp),
    .Funct3  (Funct3),
    .Funct7  (Funct7),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  // in_ready comes straight from the skid flop, so it never depends on out_ready.
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign main_free = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      Operation    <= '0;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      skid_valid   <= 1'b0;
      skid_op      <= '0;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
    end else if (main_free) begin
      // A full skid implies in_ready=0, so no new input competes with it here.
      if (skid_valid) begin
        out_valid   <= 1'b1;
        Operation   <= skid_op;
        out_illegal <= skid_illegal;
        out_tag     <= skid_tag;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        Operation   <= OPCODE_LENGTH'(dec_op);
        out_illegal <= dec_illegal;
        out_tag     <= in_tag;
      end else begin
        out_valid   <= 1'b0;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_op      <= OPCODE_LENGTH'(dec_op);
      skid_illegal <= dec_illegal;
      skid_tag     <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count <= '0;
    end else if (accept && dec_illegal && (illegal_count != {CNT_WIDTH{1'b1}})) begin
      illegal_count <= illegal_count + CNT_WIDTH'(1);
    end
  end

endmodule
